// File: rtl/slipstream_clkgen.sv
// Derived-clock generator for MasterClock-time mode: divides MasterClock into a
// glitch-free clk_out with programmable half-period, rise/fall strobes and a stall handshake.
module slipstream_clkgen #(
  parameter int          DIV_W     = 4,
  parameter int unsigned DIV_RESET = 1,
  parameter int          CNT_W     = 16
) (
  input  logic             MasterClock,
  input  logic             resetL,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  input  logic             stall_req,
  output logic             stall_ack,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             clk_fall,
  output logic [CNT_W-1:0] cyc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STALLED = 2'd2
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_active_q;
  logic [DIV_W-1:0] div_pending_q;
  logic             pend_valid_q;

  // A load in the same cycle as an application point wins over the held value.
  logic [DIV_W-1:0] div_pending_d;
  logic             pend_valid_d;
  logic [DIV_W-1:0] reload_div;

  assign div_pending_d = div_load ? div : div_pending_q;
  assign pend_valid_d  = div_load | pend_valid_q;
  assign reload_div    = pend_valid_d ? div_pending_d : div_active_q;

  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      div_active_q  <= DIV_W'(DIV_RESET);
      div_pending_q <= '0;
      pend_valid_q  <= 1'b0;
      clk_out       <= 1'b0;
      clk_rise      <= 1'b0;
      clk_fall      <= 1'b0;
      stall_ack     <= 1'b0;
      cyc           <= '0;
    end else begin
      clk_rise      <= 1'b0;
      clk_fall      <= 1'b0;
      div_pending_q <= div_pending_d;
      pend_valid_q  <= pend_valid_d;
      case (state_q)
        S_IDLE: begin
          clk_out   <= 1'b0;
          stall_ack <= 1'b0;
          if (pend_valid_d) begin
            div_active_q <= div_pending_d;
            pend_valid_q <= 1'b0;
          end
          if (run) begin
            state_q <= S_RUN;
            cnt_q   <= reload_div;
          end
        end
        S_RUN: begin
          // Parking is only allowed while low; a high phase always runs to completion.
          if (!clk_out && (!run || stall_req)) begin
            state_q   <= run ? S_STALLED : S_IDLE;
            stall_ack <= run;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (clk_out) begin
            clk_out      <= 1'b0;
            clk_fall     <= 1'b1;
            cnt_q        <= reload_div;
            div_active_q <= reload_div;
            pend_valid_q <= 1'b0;
            if (!run) begin
              state_q <= S_IDLE;
            end else if (stall_req) begin
              state_q   <= S_STALLED;
              stall_ack <= 1'b1;
            end
          end else begin
            clk_out  <= 1'b1;
            clk_rise <= 1'b1;
            cyc      <= cyc + 1'b1;
            cnt_q    <= div_active_q;
          end
        end
        S_STALLED: begin
          clk_out <= 1'b0;
          if (pend_valid_d) begin
            div_active_q <= div_pending_d;
            pend_valid_q <= 1'b0;
          end
          if (!run) begin
            state_q   <= S_IDLE;
            stall_ack <= 1'b0;
          end else if (!stall_req) begin
            state_q   <= S_RUN;
            stall_ack <= 1'b0;
            cnt_q     <= reload_div;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slipstream_clkgen.sv
// Randomized bench for slipstream_clkgen against a phase-length reference model.
module tb_slipstream_clkgen;

  localparam int DIV_W = 4;
  localparam int CNT_W = 4;

  logic             MasterClock;
  logic             resetL;
  logic             run;
  logic [DIV_W-1:0] div;
  logic             div_load;
  logic             stall_req;
  logic             stall_ack;
  logic             clk_out;
  logic             clk_rise;
  logic             clk_fall;
  logic [CNT_W-1:0] cyc;

  slipstream_clkgen #(.DIV_W(DIV_W), .DIV_RESET(1), .CNT_W(CNT_W)) dut (
    .MasterClock(MasterClock),
    .resetL     (resetL),
    .run        (run),
    .div        (div),
    .div_load   (div_load),
    .stall_req  (stall_req),
    .stall_ack  (stall_ack),
    .clk_out    (clk_out),
    .clk_rise   (clk_rise),
    .clk_fall   (clk_fall),
    .cyc        (cyc)
  );

  initial MasterClock = 1'b0;
  always #5 MasterClock = ~MasterClock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Model: 0=idle 1=run 2=stalled; a phase lasts m_len edges counted by m_age.
  int m_mode, m_age, m_len, m_active, m_pend, m_cyc;
  bit m_pv, m_clk, m_rise, m_fall, m_ack;

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_len = 0; m_active = 1; m_pend = 0; m_pv = 0;
    m_clk = 0; m_rise = 0; m_fall = 0; m_ack = 0; m_cyc = 0;
  endtask

  task automatic apply_pending();
    if (m_pv) begin
      m_active = m_pend;
      m_pv = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit dl, input int dv);
    m_rise = 0;
    m_fall = 0;
    if (dl) begin
      m_pend = dv;
      m_pv = 1;
    end
    case (m_mode)
      0: begin
        apply_pending();
        if (r) begin
          m_mode = 1; m_age = 0; m_len = m_active + 1;
        end
      end
      1: begin
        if (!m_clk && (!r || st)) begin
          m_mode = r ? 2 : 0;
          m_ack = r;
        end else begin
          m_age++;
          if (m_age == m_len) begin
            m_age = 0;
            if (m_clk) begin
              m_clk = 0; m_fall = 1;
              apply_pending();
              m_len = m_active + 1;
              if (!r) m_mode = 0;
              else if (st) begin
                m_mode = 2; m_ack = 1;
              end
            end else begin
              m_clk = 1; m_rise = 1;
              m_cyc = (m_cyc + 1) % (1 << CNT_W);
              m_len = m_active + 1;
            end
          end
        end
      end
      default: begin
        apply_pending();
        if (!r) begin
          m_mode = 0; m_ack = 0;
        end else if (!st) begin
          m_mode = 1; m_ack = 0; m_age = 0; m_len = m_active + 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check_val("clk_out", 32'(clk_out), 32'(m_clk));
    check_val("clk_rise", 32'(clk_rise), 32'(m_rise));
    check_val("clk_fall", 32'(clk_fall), 32'(m_fall));
    check_val("stall_ack", 32'(stall_ack), 32'(m_ack));
    check_val("cyc", 32'(cyc), 32'(m_cyc));
  endtask

  task automatic cycle(input bit r, input bit st, input bit dl, input int dv);
    run = r; stall_req = st; div_load = dl; div = DIV_W'(dv);
    @(posedge MasterClock);
    model_step(r, st, dl, dv);
    @(negedge MasterClock);
    compare_all();
  endtask

  task automatic async_reset();
    resetL = 1'b0;
    #1;
    model_reset();
    check_val("rst_clk_out", 32'(clk_out), 32'(m_clk));
    check_val("rst_clk_fall", 32'(clk_fall), 32'(m_fall));
    check_val("rst_clk_rise", 32'(clk_rise), 32'(m_rise));
    check_val("rst_cyc", 32'(cyc), 32'(m_cyc));
    check_val("rst_stall_ack", 32'(stall_ack), 32'(m_ack));
    @(negedge MasterClock);
    resetL = 1'b1;
  endtask

  bit r_lvl, st_lvl;
  int n_resets;

  initial begin
    resetL = 1'b0; run = 1'b0; div = '0; div_load = 1'b0; stall_req = 1'b0;
    model_reset();
    repeat (2) @(negedge MasterClock);
    compare_all();
    resetL = 1'b1;

    // Load div=2 while idle, then free-run: 3-high/3-low, cyc wraps after 16 rises.
    cycle(0, 0, 1, 2);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 110; i++) cycle(1, 0, 0, 0);
    // div=0: toggle every cycle.
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
    // div=3, then load 1 mid-high-phase.
    cycle(1, 0, 1, 3);
    while (!(m_clk && m_age == 1)) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0);
    // Stall requested one cycle into a high phase at div=3, then released.
    cycle(1, 0, 1, 3);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    while (!(m_clk && m_age == 0)) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    // run=0 with stall_req=1 while low goes idle without ack.
    while (m_clk) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    // Asynchronous reset while high.
    while (!m_clk) cycle(1, 0, 0, 0);
    async_reset();

    r_lvl = 1; st_lvl = 0; n_resets = 0;
    for (int i = 0; i < 4000; i++) begin
      int dv;
      bit dl;
      if (r_lvl) r_lvl = ($urandom_range(0, 59) != 0);
      else r_lvl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) st_lvl = !st_lvl;
      dl = ($urandom_range(0, 19) == 0);
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      cycle(r_lvl, st_lvl, dl, dv);
      if (m_clk && $urandom_range(0, 399) == 0) begin
        async_reset();
        n_resets++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slipstream_clkgen.md
# slipstream_clkgen

Derived-clock and edge-strobe generator for the Slipstream cell library when it is built in MasterClock-time mode. Edge-sampled primitives, such as the JK and D flip-flops, detect a 0→1 transition on their `clk` input under MasterClock; this block is the driving end of that interface. It divides MasterClock into a glitch-free derived clock with programmable half-period. It also emits aligned rise/fall strobes and supports a run/stall handshake, so the emulated chip can be frozen only while its clock is low.

## Interface
Parameters:
- DIV_W, 4: width of the half-period divisor.
- DIV_RESET, 1: divisor value after reset.
- CNT_W, 16: width of the derived-cycle counter.

Ports:
- MasterClock  in  1  sole clock; all state is updated on its rising edge.
- resetL  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = generate clock, 0 = park the clock low.
- div  in  DIV_W  requested divisor; half-period = div+1 MasterClock cycles.
- div_load  in  1  one-cycle strobe that captures `div`.
- stall_req  in  1  level; request to freeze the clock low.
- stall_ack  out  1  1 = clock is parked low because of a stall.
- clk_out  out  1  registered derived clock.
- clk_rise  out  1  1 in the cycle where clk_out first reads 1.
- clk_fall  out  1  1 in the cycle where clk_out first reads 0.
- cyc  out  CNT_W  count of rising edges; wraps modulo 2^CNT_W.

## Operation
- Registers:
  - half-period down-counter `cnt` (DIV_W bits);
  - `div_active` and `div_pending` (DIV_W bits each);
  - `pend_valid` flag;
  - state register.
- Reset values:
  - clk_out=0, clk_rise=0, clk_fall=0, stall_ack=0, cyc=0;
  - cnt=0, div_active=DIV_RESET, pend_valid=0, state=IDLE.
- States:
  - IDLE: clk_out is held at 0.
    - run=1 → RUN, loading cnt=div_active.
  - RUN: if cnt≠0, decrement cnt. If cnt==0, toggle clk_out and reload cnt.
    - If the toggle is 1→0 (a fall) and run=0 → IDLE.
    - If the toggle is 1→0 (a fall) and stall_req=1 (run=1) → STALLED.
    - If clk_out is already 0 and either run=0 or stall_req=1 → leave immediately without toggling: IDLE if run=0, STALLED otherwise.
    - run=0 takes priority over stall_req.
  - STALLED: clk_out=0 and stall_ack=1.
    - stall_req=0 → RUN with cnt=div_active; stall_ack drops the same cycle.
    - run=0 → IDLE, stall_ack=0.
- A high phase is never truncated. Once clk_out=1, it stays 1 for the full div_active+1 cycles regardless of run or stall_req.
- Divisor update:
  - div_load captures div into div_pending and sets pend_valid.
  - The pending value is applied at the next 1→0 toggle: div_active←div_pending, pend_valid←0, and the reload uses the new value.
  - In IDLE or STALLED, the pending value is applied the next cycle.
  - If div_load coincides with a fall, the newly loaded div is used for that same reload.
  - A second div_load before application overwrites div_pending.
- div=0 is legal and gives a half-period of 1 cycle, i.e. clk_out toggles every MasterClock cycle.
- cyc increments by 1 on each 0→1 toggle and wraps from 2^CNT_W−1 to 0.

## Timing
- Strobes are registered together with clk_out. clk_rise=1 exactly when clk_out changes 0→1; clk_fall=1 exactly when it changes 1→0. Each strobe lasts one MasterClock cycle.
- The cyc increment is visible in the same cycle as clk_rise.
- Start-up: if run is first sampled high at edge N, the state is RUN from edge N+1, and clk_out=1 and clk_rise=1 from edge N+2+div_active.
- Period: 2·(div_active+1) cycles; duty cycle 50%.
- Stall latency, with stall_req sampled at edge M:
  - if clk_out=0, stall_ack=1 from edge M+1;
  - if clk_out=1, stall_ack=1 in the cycle of the next fall, coincident with clk_fall.
- Restart: stall_req=0 sampled at edge R gives stall_ack=0 from R+1 and the next rise at R+2+div_active, so a full low phase is guaranteed.
- Asynchronous reset mid-high-phase forces clk_out=0 immediately, with no clk_fall strobe. On release, the block resumes in IDLE.

## Test plan
- Reset, run=1, div=2 (DIV_RESET overridden by loading 2 while IDLE) → clk_out period 6 cycles (3 high, 3 low); clk_rise and clk_fall each one cycle wide; cyc=1,2,3 on successive rises.
- div=0 → clk_out toggles every cycle; the strobes alternate each cycle; cyc increments every 2 cycles.
- Running at div=3, then div_load with div=1 issued mid-high-phase → current high phase stays 4 cycles; the following low phase is 2 cycles; all later half-periods are 2 cycles. Also repeat with div_load coincident with clk_fall → new value applied to that reload.
- stall_req raised 1 cycle into a high phase (div=3) → clk_out stays high 3 more cycles; stall_ack=1 with clk_fall; clock held low. Drop stall_req → stall_ack=0 next cycle; rise div+2 cycles after the drop is sampled.
- run=0 and stall_req=1 together while low → IDLE, stall_ack remains 0.
- CNT_W=4, run for 16 rises → cyc wraps 15→0. Assert resetL=0 while clk_out=1 → clk_out=0 asynchronously, no strobe, cyc=0.
